// File: rtl/avmm_sample_logger.sv
// avmm_sample_logger: Avalon-MM write master that streams 32-bit telemetry
// samples through a small FIFO into a linear or circular window of RAM words.
// The FIFO head stays occupied while its write is in flight; the write port
// is fully registered so address/data hold steady under waitrequest.
`timescale 1ns/1ps

module avmm_sample_logger #(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int BASE_WORD  = 0,
  parameter int LEN_WORDS  = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              circular,
  input  logic              sample_valid,
  input  logic [31:0]       sample_data,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   wr_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_WORD);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BASE_WORD + LEN_WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_CNT   = (ADDR_W+1)'(LEN_WORDS);
  localparam logic [ADDR_W:0]   LEN_LAST  = (ADDR_W+1)'(LEN_WORDS - 1);
  localparam logic [ADDR_W:0]   WCNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

  // Control / status state
  logic [1:0]        state_reg, state_next;
  logic              circ_reg;
  logic              overflow_reg;
  logic [ADDR_W:0]   wr_count_reg;

  // Sample FIFO (head = oldest entry, occupied until its write completes)
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_inc;
  logic [PTR_W:0]    count_reg, count_next;

  // Registered Avalon write port
  logic              write_reg;
  logic [31:0]       wdata_reg;
  logic [ADDR_W-1:0] addr_reg;

  // Per-cycle events
  logic in_run;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic drop;
  logic complete;
  logic start_run;
  logic limit_hit;
  logic flush;

  assign in_run     = (state_reg == ST_RUN);
  assign fifo_full  = (count_reg == FULL_CNT);
  assign fifo_empty = (count_reg == '0);
  assign push       = in_run && sample_valid && !fifo_full;
  assign drop       = in_run && sample_valid && fifo_full;
  assign complete   = write_reg && !avm_waitrequest;
  assign start_run  = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  // Linear mode stops on the completion that brings wr_count to LEN_WORDS.
  assign limit_hit  = complete && !circ_reg && (wr_count_reg == LEN_LAST);
  // Entering a run, or hitting the linear limit, discards anything queued.
  assign flush      = start_run || limit_hit;
  assign rd_ptr_inc = rd_ptr_reg + PTR_ONE;

  // Next-state logic: start wins in IDLE/DONE, limit then stop win in RUN.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        if (limit_hit)  state_next = ST_DONE;
        else if (stop)  state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (limit_hit || (fifo_empty && !write_reg)) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FIFO occupancy: +1 per push, -1 per completed write.
  always_comb begin
    count_next = count_reg;
    case ({push, complete})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // FIFO storage: plain array write, read back through the write-data register.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= sample_data;
  end

  // Main sequencer: state, FIFO pointers, write port and run statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      circ_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      wr_count_reg <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      write_reg    <= 1'b0;
      wdata_reg    <= '0;
      addr_reg     <= BASE_ADDR;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;

      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;

      if (complete) begin
        rd_ptr_reg <= rd_ptr_inc;
        addr_reg   <= (addr_reg == LAST_ADDR) ? BASE_ADDR : addr_reg + ADDR_ONE;
        if (wr_count_reg != LEN_CNT) wr_count_reg <= wr_count_reg + WCNT_ONE;
        // Chain straight into the next entry when one is already queued
        // behind the head, giving one word per cycle.
        if (count_reg > CNT_ONE) begin
          write_reg <= 1'b1;
          wdata_reg <= fifo_mem[rd_ptr_inc];
        end else begin
          write_reg <= 1'b0;
        end
      end else if (!write_reg && !fifo_empty) begin
        write_reg <= 1'b1;
        wdata_reg <= fifo_mem[rd_ptr_reg];
      end

      if (drop) overflow_reg <= 1'b1;

      if (start_run) begin
        circ_reg     <= circular;
        addr_reg     <= BASE_ADDR;
        wr_count_reg <= '0;
        overflow_reg <= 1'b0;
      end

      if (flush) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
        write_reg  <= 1'b0;
      end
    end
  end

  assign avm_address    = addr_reg;
  assign avm_byteenable = 4'hF;
  assign avm_chipselect = write_reg;
  assign avm_write      = write_reg;
  assign avm_writedata  = wdata_reg;
  assign busy           = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
  assign done           = (state_reg == ST_DONE);
  assign overflow       = overflow_reg;
  assign wr_count       = wr_count_reg;

endmodule

// File: tb/tb_avmm_sample_logger.sv
// Bench for avmm_sample_logger: expected writes are queued as samples are
// driven and matched against completed Avalon writes by a negedge monitor.
`timescale 1ns/1ps

module tb_avmm_sample_logger;

  localparam int BASE = 16;
  localparam int LEN  = 8;
  localparam logic [11:0] BASE_A = 12'd16;
  localparam logic [11:0] LAST_A = 12'd23;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic        circular;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic [11:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_chipselect;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [12:0] wr_count;

  avmm_sample_logger #(
    .ADDR_W(12), .FIFO_DEPTH(8), .BASE_WORD(BASE), .LEN_WORDS(LEN)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .circular(circular),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .overflow(overflow), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] exp_ptr;
  logic [31:0] shadow [0:4095];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_wr = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [31:0] d);
    exp_t e;
    e.addr = exp_ptr;
    e.data = d;
    exp_q.push_back(e);
    exp_ptr = (exp_ptr == LAST_A) ? BASE_A : exp_ptr + 12'd1;
  endtask

  task automatic do_start(input logic circ);
    circular = circ;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    exp_ptr  = BASE_A;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  task automatic wait_write(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 16 && !seen; k++) begin
      @(negedge clk);
      if (avm_write) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  // Monitor: a write completes on the next edge when write=1 and waitrequest=0.
  always @(negedge clk) begin
    if (!reset && avm_write && !avm_waitrequest) begin
      exp_t e;
      n_wr++;
      shadow[avm_address] = avm_writedata;
      $display("write addr=%0d data=%08h wr_count=%0d", avm_address, avm_writedata, wr_count);
      check("wr_cs", 64'(avm_chipselect), 64'd1);
      check("wr_be", 64'(avm_byteenable), 64'hF);
      check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(avm_address), 64'(e.addr));
        check("wr_data", 64'(avm_writedata), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int base_wr;
    reset = 1'b1; start = 1'b0; stop = 1'b0; circular = 1'b0;
    sample_valid = 1'b0; sample_data = '0; avm_waitrequest = 1'b0;
    exp_ptr = BASE_A;
    repeat (3) tick();
    @(negedge clk);
    check("rst_write", 64'(avm_write), 64'd0);
    check("rst_cs", 64'(avm_chipselect), 64'd0);
    check("rst_addr", 64'(avm_address), 64'd16);
    check("rst_wdata", 64'(avm_writedata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_wrcnt", 64'(wr_count), 64'd0);
    tick();
    reset = 1'b0;

    // 1: linear fill, ninth sample must never reach RAM
    do_start(1'b0);
    base_wr = n_wr;
    for (int i = 0; i < 9; i++) begin
      sample_valid = 1'b1;
      sample_data  = 32'hA0 + 32'(i);
      if (i < 8) expect_wr(sample_data);
      tick();
    end
    sample_valid = 1'b0;
    wait_done("t1_done");
    check("t1_wrcnt", 64'(wr_count), 64'd8);
    check("t1_ovf", 64'(overflow), 64'd0);
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_nwr", 64'(n_wr - base_wr), 64'd8);
    check("t1_sb_left", 64'(exp_q.size()), 64'd0);

    // 2: three-cycle stall on the second write
    do_start(1'b0);
    base_wr = n_wr;
    sample_valid = 1'b1; sample_data = 32'hA0; expect_wr(sample_data);
    tick();
    sample_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("t2_wrcnt1", 64'(wr_count), 64'd1);
    tick();
    avm_waitrequest = 1'b1;
    sample_valid = 1'b1; sample_data = 32'hA1; expect_wr(sample_data);
    tick();
    sample_valid = 1'b0;
    wait_write("t2_write_seen");
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        tick();
        if (k == 3) avm_waitrequest = 1'b0;
        @(negedge clk);
      end
      check("t2_hold_addr", 64'(avm_address), 64'd17);
      check("t2_hold_data", 64'(avm_writedata), 64'hA1);
      check("t2_hold_wr", 64'(avm_write), 64'd1);
    end
    tick();
    @(negedge clk);
    check("t2_wr_low", 64'(avm_write), 64'd0);
    check("t2_wrcnt2", 64'(wr_count), 64'd2);
    check("t2_nwr", 64'(n_wr - base_wr), 64'd2);
    pulse_stop();
    wait_done("t2_done");

    // 3: circular wrap, then stop and drain
    do_start(1'b1);
    base_wr = n_wr;
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1'b1;
      sample_data  = 32'hB0 + 32'(i);
      expect_wr(sample_data);
      tick();
    end
    sample_valid = 1'b0;
    pulse_stop();
    @(negedge clk);
    check("t3_done_early", 64'(done), 64'd0);
    check("t3_busy_drain", 64'(busy), 64'd1);
    wait_done("t3_done");
    check("t3_wrcnt_sat", 64'(wr_count), 64'd8);
    check("t3_nwr", 64'(n_wr - base_wr), 64'd10);
    check("t3_word16", 64'(shadow[16]), 64'hB8);
    check("t3_word17", 64'(shadow[17]), 64'hB9);
    check("t3_sb_left", 64'(exp_q.size()), 64'd0);

    // 4: overflow under a stalled slave
    do_start(1'b0);
    base_wr = n_wr;
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1'b1;
      sample_data  = 32'hC0 + 32'(i);
      if (i < 8) expect_wr(sample_data);
      tick();
    end
    sample_valid = 1'b0;
    @(negedge clk);
    check("t4_ovf", 64'(overflow), 64'd1);
    check("t4_stalled", 64'(avm_write), 64'd1);
    tick();
    avm_waitrequest = 1'b0;
    wait_done("t4_done");
    check("t4_nwr", 64'(n_wr - base_wr), 64'd8);
    check("t4_wrcnt", 64'(wr_count), 64'd8);
    check("t4_ovf_sticky", 64'(overflow), 64'd1);
    check("t4_sb_left", 64'(exp_q.size()), 64'd0);

    // 5: stop with data still queued behind a stall
    do_start(1'b1);
    base_wr = n_wr;
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1;
      sample_data  = 32'hD0 + 32'(i);
      expect_wr(sample_data);
      tick();
    end
    sample_valid = 1'b0;
    pulse_stop();
    for (int i = 0; i < 2; i++) begin
      sample_valid = 1'b1;
      sample_data  = 32'hE0 + 32'(i);
      tick();
    end
    sample_valid = 1'b0;
    tick();
    avm_waitrequest = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (n_wr - base_wr == 3) seen = 1'b1;
      end
      check("t5_last_wr_seen", 64'(seen), 64'd1);
    end
    @(negedge clk);
    @(negedge clk);
    check("t5_done", 64'(done), 64'd1);
    check("t5_nwr", 64'(n_wr - base_wr), 64'd3);
    check("t5_wrcnt", 64'(wr_count), 64'd3);
    check("t5_ovf", 64'(overflow), 64'd0);
    check("t5_sb_left", 64'(exp_q.size()), 64'd0);

    // 6: reset while a write is stalled, then a clean run
    do_start(1'b0);
    avm_waitrequest = 1'b1;
    sample_valid = 1'b1; sample_data = 32'hF0;
    tick();
    sample_valid = 1'b0;
    wait_write("t6_write_seen");
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("t6_wr_low", 64'(avm_write), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_wrcnt", 64'(wr_count), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_addr", 64'(avm_address), 64'd16);
    tick();
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    do_start(1'b0);
    base_wr = n_wr;
    for (int i = 0; i < 2; i++) begin
      sample_valid = 1'b1;
      sample_data  = 32'h60 + 32'(i);
      expect_wr(sample_data);
      tick();
    end
    sample_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("t6_run_wrcnt", 64'(wr_count), 64'd2);
    check("t6_run_nwr", 64'(n_wr - base_wr), 64'd2);
    pulse_stop();
    wait_done("t6_run_done");
    check("t6_sb_left", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/avmm_sample_logger.md
Name: avmm_sample_logger

Overview:
- Avalon-MM write master: the initiator-side counterpart of the single-port on-chip RAM slave. Streams 32-bit samples (PWM/motor telemetry) into RAM words.
- Samples pass through a small FIFO, then go out as single-word writes to a linear or circular window of RAM.
- The Nios II reads the window back after the run.

Parameters:
- ADDR_W, 12, word-address width; matches the 4096-word RAM.
- FIFO_DEPTH, 8, sample FIFO entries; must be a power of two, at least 2.
- BASE_WORD, 0, first word address of the log window.
- LEN_WORDS, 4096, window length in words; BASE_WORD+LEN_WORDS must not exceed 2^ADDR_W.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a run.
- stop  in  1  one-cycle pulse that ends a run after draining.
- circular  in  1  1 = wrap in the window; 0 = stop when the window is full. Sampled on start.
- sample_valid  in  1  one-cycle strobe; the source has no backpressure.
- sample_data  in  32  sample word.
- avm_address  out  ADDR_W  word address.
- avm_byteenable  out  4  constant 4'hF.
- avm_chipselect  out  1  equals avm_write.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  level, high in DONE.
- overflow  out  1  sticky flag: a sample was dropped.
- wr_count  out  ADDR_W+1  completed writes, saturating at LEN_WORDS.

Behaviour:
- Reset (synchronous, active-high, wins over everything): state=IDLE, FIFO flushed, write pointer=BASE_WORD.
  - Outputs after reset: avm_write=0, chipselect=0, address=BASE_WORD, writedata=0, busy=0, done=0, overflow=0, wr_count=0.
  - Reset while a write is stalled drops avm_write on the next edge. No completion is counted.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start -> RUN. On entry: pointer=BASE_WORD, wr_count=0, overflow=0, done=0, FIFO flushed, circular latched.
  - RUN + stop -> DRAIN. If start and stop arrive together: start wins in IDLE/DONE, stop wins in RUN. start in RUN or DRAIN is ignored.
  - RUN, circular=0, wr_count reaches LEN_WORDS -> DONE. No further samples are accepted.
  - DRAIN, FIFO empty and no write outstanding -> DONE.
- Sample capture (RUN only):
  - sample_valid with FIFO not full: push sample_data.
  - sample_valid with FIFO full: drop the sample, set overflow (sticky until the next start or reset).
  - In IDLE, DRAIN or DONE: samples are ignored and overflow is not set.
- FIFO occupancy: the FIFO head stays occupied until its write completes. Full means FIFO_DEPTH entries, including the head.
- Write side (registered):
  - avm_write asserts no earlier than 1 cycle after the push, whenever the FIFO is non-empty.
  - A write completes on any edge where avm_write=1 and avm_waitrequest=0.
  - While waitrequest=1: address and writedata stay stable and avm_write stays high. No duplicate write is issued.
  - On completion: pop the FIFO; pointer+1, wrapping from BASE_WORD+LEN_WORDS-1 to BASE_WORD; wr_count+1, saturating at LEN_WORDS.
  - Back-to-back writes are allowed, giving 1 word/cycle with waitrequest=0.
- Linear mode (circular=0): at most LEN_WORDS writes per run. A pending FIFO entry beyond the limit is discarded on entry to DONE.
- Window bounds: avm_address never leaves [BASE_WORD, BASE_WORD+LEN_WORDS-1].

Test Plan:
1. Linear fill, bench params BASE_WORD=16, LEN_WORDS=8, waitrequest=0:
   - Stimulus: start, then 9 strobes with data 0xA0..0xA8.
   - Required: 8 writes to addresses 16..23 carrying 0xA0..0xA7; done=1; wr_count=8; overflow=0; 0xA8 never written.
2. Waitrequest stall:
   - Stimulus: hold waitrequest=1 for 3 cycles on the second write.
   - Required: address 17 and data 0xA1 held stable for 4 cycles; exactly one completion; wr_count advances by 1.
3. Circular wrap, same window, circular=1:
   - Stimulus: 10 samples 0xB0..0xB9, then stop.
   - Required: addresses 16..23, 16, 17; words 16 and 17 hold 0xB8 and 0xB9; wr_count=8 (saturated); done=1 only after the drain.
4. Overflow, FIFO_DEPTH=8:
   - Stimulus: waitrequest=1; 10 consecutive strobes; then release waitrequest.
   - Required: overflow=1; exactly 8 writes of the first 8 samples.
5. Stop with pending data:
   - Stimulus: 3 samples queued under stall, then stop, then release.
   - Required: all 3 written; samples arriving after stop are ignored; done=1 one cycle after the last completion.
6. Reset mid-write:
   - Stimulus: reset while avm_write=1 and waitrequest=1.
   - Required: next cycle avm_write=0, busy=0, wr_count=0, state IDLE; a following start runs normally from BASE_WORD.
